// File: rtl/csr_timer.sv
// Constant-countdown timer CSR block (TCFG/TVAL/TICLR + TI status).
// Define TIMER_PRESCALE_EN to count one tick every PRESCALE clocks instead of every clock.
module csr_timer #(
  parameter int TIMER_W  = 32,
  parameter int PRESCALE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tcfg_wen,
  input  logic               ticlr_wen,
  input  logic [TIMER_W-1:0] csr_wdata,
  input  logic               ecfg_lie_ti,
  output logic [TIMER_W-1:0] tcfg_rdata,
  output logic [TIMER_W-1:0] tval_rdata,
  output logic               estat_ti,
  output logic               csr_timer_intr_sync
);

  if (TIMER_W < 8 || PRESCALE < 2) begin : g_param_check
    $error("csr_timer: TIMER_W must be >= 8 and PRESCALE >= 2");
  end

  logic [TIMER_W-1:0] tcfg_q, tval_q, reload;
  logic               ti_q, en, periodic, tick, count, fire;

  assign en       = tcfg_q[0];
  assign periodic = tcfg_q[1];
  assign reload   = {tcfg_q[TIMER_W-1:2], 2'b00};

`ifdef TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] presc_q;

  assign tick = (presc_q == PW'(PRESCALE-1));

  // Restart on every TCFG write so the fire latency is exact from the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         presc_q <= '0;
    else if (tcfg_wen) presc_q <= '0;
    else if (en)       presc_q <= tick ? '0 : presc_q + 1'b1;
  end
`else
  assign tick = 1'b1;
`endif

  // tval_q == 0 is the idle state: never decremented, never wraps.
  assign count = ~tcfg_wen & en & (tval_q != '0) & tick;
  assign fire  = count & (tval_q == TIMER_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcfg_q <= '0;
      tval_q <= '0;
      ti_q   <= 1'b0;
    end else begin
      if (tcfg_wen) begin
        tcfg_q <= csr_wdata;
        tval_q <= {csr_wdata[TIMER_W-1:2], 2'b00};
      end else if (fire) begin
        tval_q <= periodic ? reload : '0;
      end else if (count) begin
        tval_q <= tval_q - 1'b1;
      end
      // A fire in the same cycle as a clear wins.
      if (fire)                           ti_q <= 1'b1;
      else if (ticlr_wen && csr_wdata[0]) ti_q <= 1'b0;
    end
  end

  assign tcfg_rdata          = tcfg_q;
  assign tval_rdata          = tval_q;
  assign estat_ti            = ti_q;
  assign csr_timer_intr_sync = ti_q & ecfg_lie_ti;

endmodule

// File: tb/tb_csr_timer.sv
// Self-checking bench for csr_timer: vector table + scoreboard queue, plus hand-written corner sequences.
module tb_csr_timer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tcfg_wen = 1'b0, ticlr_wen = 1'b0, ecfg_lie_ti = 1'b0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] tcfg_rdata, tval_rdata;
  logic        estat_ti, csr_timer_intr_sync;

  csr_timer #(.TIMER_W(32), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .tcfg_wen(tcfg_wen), .ticlr_wen(ticlr_wen),
    .csr_wdata(csr_wdata), .ecfg_lie_ti(ecfg_lie_ti), .tcfg_rdata(tcfg_rdata),
    .tval_rdata(tval_rdata), .estat_ti(estat_ti), .csr_timer_intr_sync(csr_timer_intr_sync)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] tval; logic ti; logic intr; } exp_t;
  typedef struct { logic tw; logic cw; logic [31:0] wd; logic lie; exp_t e; } vec_t;

  exp_t sbq[$];
  vec_t tbl[$];
  int   n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  function automatic vec_t v(input logic tw, input logic cw, input logic [31:0] wd, input logic lie,
                             input logic [31:0] tv, input logic ti, input logic it);
    vec_t r;
    r.tw = tw; r.cw = cw; r.wd = wd; r.lie = lie;
    r.e.tval = tv; r.e.ti = ti; r.e.intr = it;
    return r;
  endfunction

  // One clock: drive at negedge, queue the expectation, compare just after the posedge.
  task automatic cyc(input string tag, input int idx, input logic tw, input logic cw,
                     input logic [31:0] wd, input logic lie, input exp_t e);
    exp_t got;
    @(negedge clk);
    tcfg_wen = tw; ticlr_wen = cw; csr_wdata = wd; ecfg_lie_ti = lie;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    chk($sformatf("%s[%0d] tval", tag, idx), tval_rdata, got.tval);
    chk($sformatf("%s[%0d] ti", tag, idx), {31'b0, estat_ti}, {31'b0, got.ti});
    chk($sformatf("%s[%0d] intr", tag, idx), {31'b0, csr_timer_intr_sync}, {31'b0, got.intr});
  endtask

  function automatic exp_t ex(input logic [31:0] tv, input logic ti, input logic it);
    exp_t r;
    r.tval = tv; r.ti = ti; r.intr = it;
    return r;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, " tcfg"}, tcfg_rdata, 32'h0);
    chk({tag, " tval"}, tval_rdata, 32'h0);
    chk({tag, " ti"}, {31'b0, estat_ti}, 32'h0);
    chk({tag, " intr"}, {31'b0, csr_timer_intr_sync}, 32'h0);
  endtask

  initial begin
    // One-shot InitVal=2: 8,7..1 then fire, then quiet for 50 cycles.
    tbl.push_back(v(1, 0, 32'h9, 1, 8, 0, 0));
    for (int k = 7; k >= 1; k--) tbl.push_back(v(0, 0, 0, 1, k, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 1));
    for (int k = 0; k < 50; k++) tbl.push_back(v(0, 0, 0, 1, 0, 1, 1));
    tbl.push_back(v(0, 1, 32'hFFFF_FFFE, 1, 0, 1, 1));   // CLR bit clear: no effect
    tbl.push_back(v(0, 1, 32'h1, 1, 0, 0, 0));
    // Periodic InitVal=1 with clears, simultaneous clear+fire, reload-priority write.
    tbl.push_back(v(1, 0, 32'h7, 1, 4, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 3, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 2, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 4, 1, 1));
    tbl.push_back(v(0, 1, 32'h1, 1, 3, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 2, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(0, 1, 32'h1, 1, 4, 1, 1));            // clear and fire together
    tbl.push_back(v(0, 1, 32'h1, 1, 3, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 2, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(1, 0, 32'h11, 1, 16, 0, 0));          // write beats pending fire
    tbl.push_back(v(0, 0, 0, 1, 15, 0, 0));
    // One-shot InitVal=1 with LIE low: TI sets, request stays low.
    tbl.push_back(v(1, 0, 32'h5, 0, 4, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 3, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #1 chk_zero("reset_held");
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 chk_zero("after_release");

    foreach (tbl[i]) cyc("vec", i, tbl[i].tw, tbl[i].cw, tbl[i].wd, tbl[i].lie, tbl[i].e);

    // LIE raised: request follows combinationally, no clock edge needed.
    @(negedge clk) ecfg_lie_ti = 1'b1;
    #1 chk("lie_raise intr", {31'b0, csr_timer_intr_sync}, 32'h1);

    // TCFG write leaves TI set; count down to 5 for the reset test.
    cyc("keep_ti", 0, 1, 0, 32'h15, 1, ex(20, 1, 1));
    chk("keep_ti tcfg", tcfg_rdata, 32'h15);
    for (int i = 1; i <= 15; i++) cyc("keep_ti", i, 0, 0, 0, 1, ex(20 - i, 1, 1));

    // Async reset mid-cycle: outputs drop with no clock edge.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_zero("async_reset");
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 6; i++) cyc("post_reset", i, 0, 0, 0, 1, ex(0, 0, 0));
    chk("post_reset tcfg", tcfg_rdata, 32'h0);

`ifdef TIMER_PRESCALE_EN
    // Prescale 4, InitVal=1: tval steps every 4 cycles, fires 16 cycles after the write.
    cyc("presc", 0, 1, 0, 32'h5, 1, ex(4, 0, 0));
    for (int k = 1; k <= 16; k++) cyc("presc", k, 0, 0, 0, 1, ex(4 - k / 4, (k == 16), (k == 16)));
    // En=0 for 3 cycles: value frozen; re-enable restarts the full prescaled period.
    cyc("freeze", 0, 1, 0, 32'h4, 1, ex(4, 1, 1));
    for (int k = 1; k <= 3; k++) cyc("freeze", k, 0, 0, 0, 1, ex(4, 1, 1));
    cyc("reen", 0, 1, 0, 32'h5, 1, ex(4, 1, 1));
    for (int k = 1; k <= 4; k++) cyc("reen", k, 0, 0, 0, 1, ex((k == 4) ? 3 : 4, 1, 1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/csr_timer.md
Name: csr_timer

Overview:
- Constant-countdown timer CSR block. Owns TCFG, TVAL and TICLR state plus the timer-interrupt status bit TI.
- Produces the level `csr_timer_intr_sync`, which the interrupt controller samples together with `vld_d` and holds until `ertn`.
- Sits in the CSR unit, directly upstream of the interrupt controller. All logic is in the core `clk` domain, so the output is already synchronous.

Parameters:
- TIMER_W, 32, width of TCFG/TVAL; minimum 8.
- PRESCALE, 4, clock cycles per counter tick; used only when TIMER_PRESCALE_EN is defined; minimum 2.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- tcfg_wen  in  1  write strobe for TCFG.
- ticlr_wen  in  1  write strobe for TICLR.
- csr_wdata  in  TIMER_W  CSR write data. TCFG layout: bit0 En, bit1 Periodic, [TIMER_W-1:2] InitVal. TICLR layout: bit0 CLR.
- ecfg_lie_ti  in  1  timer local-interrupt enable (ECFG.LIE[11]).
- tcfg_rdata  out  TIMER_W  current TCFG.
- tval_rdata  out  TIMER_W  current TVAL.
- estat_ti  out  1  TI status bit, for ESTAT read.
- csr_timer_intr_sync  out  1  timer interrupt request level = estat_ti & ecfg_lie_ti.

Behaviour:
- Reset (async, active-high): tcfg_q=0, tval_q=0, ti_q=0, prescaler=0. All outputs are 0 while reset is high and on the first cycle after release.
- Counter tick ("tick"): every cycle without the macro; see Optional Feature for the macro case.
- Per-cycle priority, highest first:
  1. tcfg_wen: tcfg_q<=csr_wdata; tval_q<={csr_wdata[TIMER_W-1:2],2'b00}. No decrement and no fire in this cycle.
  2. Count: when En=1 and tval_q!=0 and tick: tval_q<=tval_q-1.
- Fire event: count condition true and tval_q==1.
  - ti_q<=1.
  - Periodic=1: tval_q<={InitVal,2'b00} instead of 0; fires again after InitVal*4 ticks.
  - Periodic=0: tval_q goes to 0 and stays there. No further fire until TCFG is rewritten.
- tval_q==0 means idle: no decrement, no fire, no wrap-around ever. Periodic with InitVal=0 is therefore permanently idle.
- En=0: tval_q frozen. Setting En=1 again requires a TCFG write, which reloads tval_q.
- TI clear: ticlr_wen & csr_wdata[0] -> ti_q<=0 next cycle. If fire occurs in the same cycle, fire wins and ti_q=1.
- ticlr_wen with csr_wdata[0]=0 has no effect. TICLR reads are not provided by this block (they return 0 in the CSR mux).
- TCFG write does not clear ti_q; only TICLR clears it.
- csr_timer_intr_sync: combinational AND of the ti_q flop and ecfg_lie_ti.
  - Asserted the cycle after the fire event.
  - Held high until TI is cleared or LIE is dropped. It is not a pulse; pulse generation is downstream.
- Latency: a TCFG write with InitVal=N (N>0) and no prescale fires with ti_q high exactly 4N cycles after the write cycle.
- tcfg_rdata/tval_rdata: direct flop outputs, zero latency.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - A counter 0..PRESCALE-1 free-runs while En=1; tick=1 when it equals PRESCALE-1, then it wraps to 0.
  - The prescaler is reset to 0 on any tcfg_wen and holds while En=0.
  - Fire latency becomes 4N*PRESCALE cycles.
- Not defined: tick=1 every cycle; the PRESCALE parameter is ignored and no prescaler flops exist.

Test Plan:
- One-shot countdown: write TCFG=0x0000_0009 (En=1, Periodic=0, InitVal=2) with ecfg_lie_ti=1. Required: tval_rdata reads 8 the cycle after the write and decrements by 1 per cycle. estat_ti and csr_timer_intr_sync rise 8 cycles after the write and stay high. tval holds 0 and there is no second fire over 50 more cycles.
- Periodic reload: write TCFG=0x0000_0007 (En=1, Periodic=1, InitVal=1). Required: a fire every 4 cycles, with tval sequence 4,3,2,1,4,3... Write TICLR=1 after each fire. Required: ti goes low for the cycles between fires and re-sets on each reload.
- Simultaneous clear and fire: issue TICLR CLR=1 in the same cycle as tval_q==1 with a tick. Required: ti_q=1 afterwards.
- Write priority and LIE gating:
  - Write TCFG=0x11 (InitVal=4) while tval_q==1 is pending. Required: no fire, and tval reloads to 16.
  - With ecfg_lie_ti=0, after a fire: estat_ti=1 but csr_timer_intr_sync=0. Raising LIE makes the output 1 the same cycle.
- Async reset mid-count: assert reset at tval=5 with ti=1. Required: all outputs 0 immediately, without waiting for a clk edge. After release there is no counting until TCFG is written.
- TIMER_PRESCALE_EN with PRESCALE=4: write InitVal=1. Required: tval steps 4→3→2→1→0 every 4 cycles and fires 16 cycles after the write. Toggle En=0 for 3 cycles. Required: tval and the prescaler freeze.
